// File: rtl/gayle_host_if.sv
// Bundles the command handshake, result and Gayle bus signals of gayle_host.
// master: the host side (drives the bus), slave: the controller/target side.
interface gayle_host_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_arg;
    logic       cmd_ready;
    logic       done;
    logic [3:0] id_out;
    logic       id_match;
    logic       svc_stat;
    logic       svc_chg;
    logic       INT2;
    logic       CS;
    logic       DS;
    logic       RW;
    logic       A18;
    logic [2:0] A;
    logic [7:0] DOUT;
    logic [7:0] DIN;

    modport master (
        input  cmd_valid, cmd, cmd_arg, INT2, DIN,
        output cmd_ready, done, id_out, id_match, svc_stat, svc_chg,
               CS, DS, RW, A18, A, DOUT
    );

    modport slave (
        output cmd_valid, cmd, cmd_arg, INT2, DIN,
        input  cmd_ready, done, id_out, id_match, svc_stat, svc_chg,
               CS, DS, RW, A18, A, DOUT
    );
endinterface

// File: rtl/gayle_host.sv
// Gayle bus initiator: runs the ID probe, INTENA write and interrupt service
// sequences as chains of SETUP/STROBE/HOLD/RECOV accesses with registered outputs.
module gayle_host #(
    parameter logic [3:0] EXPECT_ID = 4'hd,
    parameter int         GAP       = 1,
    parameter bit         AUTO_SVC  = 1'b1
) (
    input  logic          CLKCPU,
    input  logic          RESET,
    gayle_host_if.master  bus
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RECOV  = 3'd4;

    localparam logic [1:0] SEQ_PROBE  = 2'd0;
    localparam logic [1:0] SEQ_INTENA = 2'd1;
    localparam logic [1:0] SEQ_SVC    = 2'd2;

    // Access descriptor {RW, A18, A[2:0], DOUT[7:0]} for a given sequence step.
    function automatic logic [12:0] access_desc(input logic [1:0] seq,
                                                input logic [2:0] step,
                                                input logic       arg);
        logic [12:0] d;
        case (seq)
            SEQ_PROBE:  d = (step == 3'd0) ? {1'b0, 1'b1, 3'd1, 8'h00}
                                           : {1'b1, 1'b1, 3'd1, 8'h00};
            SEQ_INTENA: d = {1'b0, 1'b0, 3'd2, arg, 7'd0};
            SEQ_SVC: begin
                case (step)
                    3'd0:    d = {1'b1, 1'b0, 3'd0, 8'h00};
                    3'd1:    d = {1'b1, 1'b0, 3'd1, 8'h00};
                    default: d = {1'b0, 1'b0, 3'd1, 8'h00};
                endcase
            end
            default:    d = {1'b1, 1'b0, 3'd0, 8'h00};
        endcase
        return d;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [1:0]    seq_q, seq_d;
    logic [2:0]    step_q, step_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          last_q, last_d;
    logic          arg_q, arg_d;
    logic [3:0]    id_shift_q, id_shift_d;
    logic          stat_tmp_q, stat_tmp_d;
    logic          chg_tmp_q, chg_tmp_d;
    logic          cs_q, cs_d, ds_q, ds_d, rw_q, rw_d, a18_q, a18_d;
    logic [2:0]    a_q, a_d;
    logic [7:0]    dout_q, dout_d;
    logic          ready_q, ready_d, done_q, done_d;
    logic [3:0]    id_out_q, id_out_d;
    logic          id_match_q, id_match_d;
    logic          svc_stat_q, svc_stat_d, svc_chg_q, svc_chg_d;
    logic          launch_s;
    logic          din_unused_s;

    assign din_unused_s = ^bus.DIN[6:0];

    // Next-state logic: sequence selection, access phasing and result capture.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        step_d     = step_q;
        gap_d      = gap_q;
        last_d     = last_q;
        arg_d      = arg_q;
        id_shift_d = id_shift_q;
        stat_tmp_d = stat_tmp_q;
        chg_tmp_d  = chg_tmp_q;
        cs_d       = cs_q;
        ds_d       = ds_q;
        rw_d       = rw_q;
        a18_d      = a18_q;
        a_d        = a_q;
        dout_d     = dout_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        id_out_d   = id_out_q;
        id_match_d = id_match_q;
        svc_stat_d = svc_stat_q;
        svc_chg_d  = svc_chg_q;
        launch_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd)
                        2'd0: begin seq_d = SEQ_PROBE;  launch_s = 1'b1; end
                        2'd1: begin seq_d = SEQ_INTENA; launch_s = 1'b1; end
                        2'd2: begin seq_d = SEQ_SVC;    launch_s = 1'b1; end
                        default: done_d = 1'b1;   // reserved: accepted, no bus activity
                    endcase
                    arg_d      = bus.cmd_arg;
                    step_d     = 3'd0;
                    id_shift_d = 4'd0;
                end else if (AUTO_SVC && bus.INT2) begin
                    seq_d    = SEQ_SVC;
                    step_d   = 3'd0;
                    launch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                ds_d    = 1'b0;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                cs_d    = 1'b1;
                ds_d    = 1'b1;
                rw_d    = 1'b1;
                gap_d   = GW'(GAP - 1);
                state_d = ST_RECOV;
                case (seq_q)
                    SEQ_PROBE: begin
                        if (step_q != 3'd0) begin
                            id_shift_d = {id_shift_q[2:0], bus.DIN[7]};
                        end else begin
                            id_shift_d = 4'd0;
                        end
                        last_d = (step_q == 3'd4);
                    end
                    SEQ_SVC: begin
                        case (step_q)
                            3'd0: begin stat_tmp_d = bus.DIN[7]; last_d = 1'b0; end
                            // Clear write only needed when a change was latched.
                            3'd1: begin chg_tmp_d = bus.DIN[7]; last_d = ~bus.DIN[7]; end
                            default: last_d = 1'b1;
                        endcase
                    end
                    default: last_d = 1'b1;
                endcase
            end
            ST_RECOV: begin
                if (gap_q != GW'(0)) begin
                    gap_d = gap_q - GW'(1);
                end else if (last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    if (seq_q == SEQ_PROBE) begin
                        id_out_d   = id_shift_q;
                        id_match_d = (id_shift_q == EXPECT_ID);
                    end else if (seq_q == SEQ_SVC) begin
                        svc_stat_d = stat_tmp_q;
                        svc_chg_d  = chg_tmp_q;
                    end else begin
                        id_out_d = id_out_q;
                    end
                end else begin
                    step_d   = step_q + 3'd1;
                    launch_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                ds_d    = 1'b1;
                rw_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase

        if (launch_s) begin
            state_d = ST_SETUP;
            cs_d    = 1'b0;
            ds_d    = 1'b1;
            ready_d = 1'b0;
            {rw_d, a18_d, a_d, dout_d} = access_desc(seq_d, step_d, arg_d);
        end else begin
            cs_d = cs_d;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            seq_q      <= SEQ_PROBE;
            step_q     <= 3'd0;
            gap_q      <= GW'(0);
            last_q     <= 1'b0;
            arg_q      <= 1'b0;
            id_shift_q <= 4'd0;
            stat_tmp_q <= 1'b0;
            chg_tmp_q  <= 1'b0;
            cs_q       <= 1'b1;
            ds_q       <= 1'b1;
            rw_q       <= 1'b1;
            a18_q      <= 1'b0;
            a_q        <= 3'd0;
            dout_q     <= 8'h00;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            id_out_q   <= 4'd0;
            id_match_q <= 1'b0;
            svc_stat_q <= 1'b0;
            svc_chg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            step_q     <= step_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            arg_q      <= arg_d;
            id_shift_q <= id_shift_d;
            stat_tmp_q <= stat_tmp_d;
            chg_tmp_q  <= chg_tmp_d;
            cs_q       <= cs_d;
            ds_q       <= ds_d;
            rw_q       <= rw_d;
            a18_q      <= a18_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            id_out_q   <= id_out_d;
            id_match_q <= id_match_d;
            svc_stat_q <= svc_stat_d;
            svc_chg_q  <= svc_chg_d;
        end
    end

    assign bus.CS        = cs_q;
    assign bus.DS        = ds_q;
    assign bus.RW        = rw_q;
    assign bus.A18       = a18_q;
    assign bus.A         = a_q;
    assign bus.DOUT      = dout_q;
    assign bus.cmd_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.id_out    = id_out_q;
    assign bus.id_match  = id_match_q;
    assign bus.svc_stat  = svc_stat_q;
    assign bus.svc_chg   = svc_chg_q;
endmodule

// File: tb/tb_gayle_host.sv
// Directed bench for gayle_host against a small Gayle target model; sequence
// results are checked through a scoreboard of expected outcomes.
module tb_gayle_host;
    logic CLKCPU = 1'b0;
    logic RESET;

    always #5 CLKCPU = ~CLKCPU;

    gayle_host_if bus();

    gayle_host #(.EXPECT_ID(4'hd), .GAP(1), .AUTO_SVC(1'b1)) dut (
        .CLKCPU (CLKCPU),
        .RESET  (RESET),
        .bus    (bus)
    );

    // Target model state
    logic [3:0]  model_id;
    logic        ide_int;
    logic        ide_prev = 1'b0;
    logic        intchg   = 1'b0;
    logic        intena   = 1'b0;
    logic        ds_prev  = 1'b1;
    logic [7:0]  din_q    = 8'h00;
    int          id_idx   = 0;
    int          acc_cnt  = 0;
    int          wr_cnt   = 0;
    int          cyc      = 0;
    logic [12:0] acc_log [0:255];

    assign bus.DIN  = din_q;
    assign bus.INT2 = intchg & intena;

    // Target model: acts once per access on the first edge with DS low after DS high.
    always @(posedge CLKCPU) begin
        cyc      <= cyc + 1;
        ds_prev  <= bus.DS;
        ide_prev <= ide_int;
        if (ide_int !== ide_prev) intchg <= 1'b1;
        if (!bus.CS && !bus.DS && ds_prev) begin
            acc_log[acc_cnt[7:0]] <= {bus.RW, bus.A18, bus.A, bus.DOUT};
            acc_cnt <= acc_cnt + 1;
            if (!bus.RW) wr_cnt <= wr_cnt + 1;
            if (bus.A18) begin
                if (bus.A == 3'd1) begin
                    if (bus.RW) begin
                        din_q  <= {model_id[3 - id_idx], 7'd0};
                        id_idx <= id_idx + 1;
                    end else begin
                        id_idx <= 0;
                    end
                end
            end else begin
                case (bus.A)
                    3'd0: if (bus.RW) din_q <= {ide_int, 7'd0};
                    3'd1: begin
                        if (bus.RW) din_q <= {intchg, 7'd0};
                        else if (!bus.DOUT[7]) intchg <= 1'b0;
                    end
                    3'd2: if (!bus.RW) intena <= bus.DOUT[7];
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        int         kind;      // 0 probe, 1 intena, 2 service, 3 reserved
        int         cycles;
        int         accesses;
        logic [3:0] id;
        logic       idm;
        logic       st;
        logic       chg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   accept_cyc = 0;
    int   acc_base = 0;
    int   wr_base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int kind, input int cycles, input int accesses,
                            input logic [3:0] id, input logic idm, input logic st, input logic chg);
        exp_t e;
        e.kind = kind; e.cycles = cycles; e.accesses = accesses;
        e.id = id; e.idm = idm; e.st = st; e.chg = chg;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] c, input logic arg);
        @(negedge CLKCPU);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.cmd_arg   = arg;
        acc_base      = acc_cnt;
        wr_base       = wr_cnt;
        @(posedge CLKCPU);
        #1;
        accept_cyc    = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLKCPU);
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (sb.size() > 0) e = sb.pop_front();
        if (seen == 1) begin
            chk({tag, "_cycles"}, cyc - accept_cyc, e.cycles);
            chk({tag, "_accesses"}, acc_cnt - acc_base, e.accesses);
            chk({tag, "_ready"}, bus.cmd_ready, 1'b1);
            if (e.kind == 0) begin
                chk({tag, "_id_out"}, bus.id_out, e.id);
                chk({tag, "_id_match"}, bus.id_match, e.idm);
            end
            if (e.kind == 2) begin
                chk({tag, "_svc_stat"}, bus.svc_stat, e.st);
                chk({tag, "_svc_chg"}, bus.svc_chg, e.chg);
            end
            @(negedge CLKCPU);
            chk({tag, "_done_pulse"}, bus.done, 1'b0);
        end
    endtask

    initial begin
        int extra;
        int seen3;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'd0;
        bus.cmd_arg   = 1'b0;
        model_id      = 4'hd;
        ide_int       = 1'b0;
        RESET         = 1'b0;
        repeat (3) @(negedge CLKCPU);
        chk("rst_bus", {bus.CS, bus.DS, bus.RW, bus.A18, bus.A, bus.DOUT}, {1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00});
        chk("rst_hs", {bus.cmd_ready, bus.done}, 2'b10);
        chk("rst_res", {bus.id_out, bus.id_match, bus.svc_stat, bus.svc_chg}, 7'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLKCPU);

        // 1: probe with matching ID
        push_exp(0, 20, 5, 4'hd, 1'b1, 1'b0, 1'b0);
        issue(2'd0, 1'b0);
        chk("t1_busy", bus.cmd_ready, 1'b0);
        wait_done("t1");

        // 2: probe with a different ID, check access encoding
        model_id = 4'ha;
        push_exp(0, 20, 5, 4'ha, 1'b0, 1'b0, 1'b0);
        issue(2'd0, 1'b0);
        wait_done("t2");
        chk("t2_first_acc", acc_log[acc_base], {1'b0, 1'b1, 3'd1, 8'h00});
        chk("t2_second_acc", acc_log[acc_base + 1], {1'b1, 1'b1, 3'd1, 8'h00});

        // 3: enable interrupt, then raise IDE_INT to trigger automatic service
        push_exp(1, 4, 1, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(2'd1, 1'b1);
        wait_done("t3w");
        chk("t3_intena_acc", acc_log[acc_base], {1'b0, 1'b0, 3'd2, 8'h80});
        push_exp(2, 12, 3, 4'h0, 1'b0, 1'b1, 1'b1);
        ide_int  = 1'b1;
        acc_base = acc_cnt;
        @(posedge CLKCPU);
        @(posedge CLKCPU);
        #1;
        accept_cyc = cyc;
        chk("t3_auto_start", bus.cmd_ready, 1'b0);
        wait_done("t3s");
        chk("t3_clear_acc", acc_log[acc_base + 2], {1'b0, 1'b0, 3'd1, 8'h00});
        chk("t3_int2_low", bus.INT2, 1'b0);
        repeat (6) @(negedge CLKCPU);
        chk("t3_no_retrigger", acc_cnt - acc_base, 3);

        // 4: explicit service with no pending change: two reads only
        push_exp(2, 8, 2, 4'h0, 1'b0, 1'b1, 1'b0);
        issue(2'd2, 1'b0);
        wait_done("t4");
        chk("t4_no_write", wr_cnt - wr_base, 0);

        // reserved command: done next cycle, no bus activity
        push_exp(3, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(2'd3, 1'b0);
        wait_done("t_rsv");

        // 5: reset during the third probe access
        model_id = 4'h5;
        issue(2'd0, 1'b0);
        seen3 = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLKCPU);
            if (acc_cnt - acc_base >= 3) begin
                seen3 = 1;
                break;
            end
        end
        chk("t5_third_access", seen3, 1);
        RESET = 1'b0;
        @(posedge CLKCPU);
        #1;
        chk("t5_rst_csds", {bus.CS, bus.DS}, 2'b11);
        chk("t5_rst_ready", bus.cmd_ready, 1'b1);
        chk("t5_rst_id", bus.id_out, 4'h0);
        @(negedge CLKCPU);
        RESET    = 1'b1;
        model_id = 4'hd;
        repeat (2) @(negedge CLKCPU);
        push_exp(0, 20, 5, 4'hd, 1'b1, 1'b0, 1'b0);
        issue(2'd0, 1'b0);
        wait_done("t5");

        // 6: command while busy is ignored
        model_id = 4'h3;
        push_exp(0, 20, 5, 4'h3, 1'b0, 1'b0, 1'b0);
        issue(2'd0, 1'b0);
        fork
            wait_done("t6");
            begin
                repeat (2) @(negedge CLKCPU);
                bus.cmd_valid = 1'b1;
                bus.cmd       = 2'd2;
                repeat (3) @(negedge CLKCPU);
                bus.cmd_valid = 1'b0;
            end
        join
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLKCPU);
            if (bus.done === 1'b1) extra++;
        end
        chk("t6_single_done", extra, 0);
        chk("t6_not_queued", acc_cnt - acc_base, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
